// File: rtl/store_queue.sv
// ---------------------------------------------------------------------------
// store_queue
//
// In-order store reservation queue for the OOO OTTER, placed directly in
// front of the store unit. Dispatch writes decoded stores (base, immediate,
// data) at the tail. Operands that are still being produced are resolved by
// snooping the common data bus. The oldest store is offered to the store unit
// once both of its register operands are known. Stores leave strictly in
// program order.
//
// Ports:
//   CLK, RST          clock and synchronous active-high reset
//   flush             discard every entry (mispredict / exception)
//   issue_*           store from dispatch, accepted on issue_valid && issue_ready
//   cdb_*             common data bus broadcast (tag + value)
//   su_*              head store offered to the store unit, popped on
//                     su_valid && su_ready
//   count             number of occupied entries
// ---------------------------------------------------------------------------
module store_queue #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     flush,
   input  logic                     issue_valid,
   output logic                     issue_ready,
   input  logic [31:0]              issue_v1,
   input  logic [TAG_W-1:0]         issue_q1,
   input  logic                     issue_v1_valid,
   input  logic [31:0]              issue_imm,
   input  logic [31:0]              issue_v3,
   input  logic [TAG_W-1:0]         issue_q3,
   input  logic                     issue_v3_valid,
   input  logic [2:0]               issue_mem_type,
   input  logic [TAG_W-1:0]         issue_tag,
   input  logic                     cdb_valid,
   input  logic [TAG_W-1:0]         cdb_tag,
   input  logic [31:0]              cdb_data,
   output logic                     su_valid,
   input  logic                     su_ready,
   output logic [31:0]              su_v1,
   output logic [31:0]              su_v2,
   output logic [31:0]              su_v3,
   output logic                     su_v1_valid,
   output logic                     su_v2_valid,
   output logic                     su_v3_valid,
   output logic [2:0]               su_mem_type,
   output logic [TAG_W-1:0]         su_tag,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;

   // Per-entry storage, packed so each entry's register block can drive its
   // own slice.
   logic [DEPTH-1:0]            ent_valid;
   logic [DEPTH-1:0][31:0]      ent_v1;
   logic [DEPTH-1:0][TAG_W-1:0] ent_q1;
   logic [DEPTH-1:0]            ent_r1;
   logic [DEPTH-1:0][31:0]      ent_imm;
   logic [DEPTH-1:0][31:0]      ent_v3;
   logic [DEPTH-1:0][TAG_W-1:0] ent_q3;
   logic [DEPTH-1:0]            ent_r3;
   logic [DEPTH-1:0][2:0]       ent_mem_type;
   logic [DEPTH-1:0][TAG_W-1:0] ent_tag;

   logic        push;
   logic        pop;
   logic        in_r1;
   logic        in_r3;
   logic [31:0] in_v1;
   logic [31:0] in_v3;

   // Handshake decisions and issue-time CDB bypass. An operand that is not
   // ready at issue can still be captured if its producer broadcasts on the
   // very same edge, otherwise it would miss that broadcast forever.
   always_comb begin
      issue_ready = (count != CNT_W'(DEPTH));
      su_valid    = ent_valid[head] && ent_r1[head] && ent_r3[head];
      push        = issue_valid && issue_ready;
      pop         = su_valid && su_ready;

      in_r1 = issue_v1_valid;
      in_v1 = issue_v1;
      if (!issue_v1_valid && cdb_valid && (cdb_tag == issue_q1)) begin
         in_r1 = 1'b1;
         in_v1 = cdb_data;
      end

      in_r3 = issue_v3_valid;
      in_v3 = issue_v3;
      if (!issue_v3_valid && cdb_valid && (cdb_tag == issue_q3)) begin
         in_r3 = 1'b1;
         in_v3 = cdb_data;
      end
   end

   // Head entry is presented combinationally; all three operand-valid flags
   // mirror su_valid because the immediate is always known.
   always_comb begin
      su_v1       = ent_v1[head];
      su_v2       = ent_imm[head];
      su_v3       = ent_v3[head];
      su_mem_type = ent_mem_type[head];
      su_tag      = ent_tag[head];
      su_v1_valid = su_valid;
      su_v2_valid = su_valid;
      su_v3_valid = su_valid;
   end

   // Pointers and occupancy. Issue and pop are independent, so a
   // simultaneous issue and pop leaves count unchanged. Flush behaves
   // exactly like reset.
   always_ff @(posedge CLK) begin
      if (RST || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head + PTR_W'(1);
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // One register block per entry. A freshly issued store overwrites the
   // slot at the tail (that slot is empty, so no capture competes with it).
   // Otherwise a valid entry watches the CDB for each unresolved operand,
   // and the head slot is released when the store unit takes it.
   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      always_ff @(posedge CLK) begin
         if (RST || flush) begin
            ent_valid[g] <= 1'b0;
         end else if (push && (tail == PTR_W'(g))) begin
            ent_valid[g]    <= 1'b1;
            ent_v1[g]       <= in_v1;
            ent_q1[g]       <= issue_q1;
            ent_r1[g]       <= in_r1;
            ent_imm[g]      <= issue_imm;
            ent_v3[g]       <= in_v3;
            ent_q3[g]       <= issue_q3;
            ent_r3[g]       <= in_r3;
            ent_mem_type[g] <= issue_mem_type;
            ent_tag[g]      <= issue_tag;
         end else begin
            if (pop && (head == PTR_W'(g))) begin
               ent_valid[g] <= 1'b0;
            end
            if (ent_valid[g] && cdb_valid && !ent_r1[g] && (ent_q1[g] == cdb_tag)) begin
               ent_v1[g] <= cdb_data;
               ent_r1[g] <= 1'b1;
            end
            if (ent_valid[g] && cdb_valid && !ent_r3[g] && (ent_q3[g] == cdb_tag)) begin
               ent_v3[g] <= cdb_data;
               ent_r3[g] <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_store_queue.sv
// ---------------------------------------------------------------------------
// tb_store_queue
//
// Self-checking bench for store_queue. A queue-of-structs reference model
// tracks the stores in program order. Directed scenarios check the
// documented cases against fixed values, and a randomized phase compares
// every cycle against the model.
// ---------------------------------------------------------------------------
module tb_store_queue;

   localparam int DEPTH = 4;
   localparam int TAG_W = 4;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             CLK;
   logic             RST;
   logic             flush;
   logic             issue_valid;
   logic             issue_ready;
   logic [31:0]      issue_v1;
   logic [TAG_W-1:0] issue_q1;
   logic             issue_v1_valid;
   logic [31:0]      issue_imm;
   logic [31:0]      issue_v3;
   logic [TAG_W-1:0] issue_q3;
   logic             issue_v3_valid;
   logic [2:0]       issue_mem_type;
   logic [TAG_W-1:0] issue_tag;
   logic             cdb_valid;
   logic [TAG_W-1:0] cdb_tag;
   logic [31:0]      cdb_data;
   logic             su_valid;
   logic             su_ready;
   logic [31:0]      su_v1;
   logic [31:0]      su_v2;
   logic [31:0]      su_v3;
   logic             su_v1_valid;
   logic             su_v2_valid;
   logic             su_v3_valid;
   logic [2:0]       su_mem_type;
   logic [TAG_W-1:0] su_tag;
   logic [CNT_W-1:0] count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0]      v1;
      logic [TAG_W-1:0] q1;
      bit               r1;
      logic [31:0]      imm;
      logic [31:0]      v3;
      logic [TAG_W-1:0] q3;
      bit               r3;
      logic [2:0]       mt;
      logic [TAG_W-1:0] tag;
   } sq_entry_t;

   // Index 0 is always the oldest store.
   sq_entry_t mq[$];

   store_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .CLK            (CLK),
      .RST            (RST),
      .flush          (flush),
      .issue_valid    (issue_valid),
      .issue_ready    (issue_ready),
      .issue_v1       (issue_v1),
      .issue_q1       (issue_q1),
      .issue_v1_valid (issue_v1_valid),
      .issue_imm      (issue_imm),
      .issue_v3       (issue_v3),
      .issue_q3       (issue_q3),
      .issue_v3_valid (issue_v3_valid),
      .issue_mem_type (issue_mem_type),
      .issue_tag      (issue_tag),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .cdb_data       (cdb_data),
      .su_valid       (su_valid),
      .su_ready       (su_ready),
      .su_v1          (su_v1),
      .su_v2          (su_v2),
      .su_v3          (su_v3),
      .su_v1_valid    (su_v1_valid),
      .su_v2_valid    (su_v2_valid),
      .su_v3_valid    (su_v3_valid),
      .su_mem_type    (su_mem_type),
      .su_tag         (su_tag),
      .count          (count)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Advance the model by one edge using the currently driven inputs, then
   // let the DUT take the same edge and settle.
   task automatic tick();
      bit        do_pop;
      bit        do_push;
      sq_entry_t e;
      if (RST || flush) begin
         mq.delete();
      end else begin
         do_pop  = (mq.size() > 0) && mq[0].r1 && mq[0].r3 && su_ready;
         do_push = issue_valid && (mq.size() < DEPTH);
         if (cdb_valid) begin
            foreach (mq[i]) begin
               e = mq[i];
               if (!e.r1 && e.q1 == cdb_tag) begin
                  e.v1 = cdb_data;
                  e.r1 = 1'b1;
               end
               if (!e.r3 && e.q3 == cdb_tag) begin
                  e.v3 = cdb_data;
                  e.r3 = 1'b1;
               end
               mq[i] = e;
            end
         end
         if (do_pop) void'(mq.pop_front());
         if (do_push) begin
            e.v1  = issue_v1;
            e.q1  = issue_q1;
            e.r1  = issue_v1_valid;
            e.imm = issue_imm;
            e.v3  = issue_v3;
            e.q3  = issue_q3;
            e.r3  = issue_v3_valid;
            e.mt  = issue_mem_type;
            e.tag = issue_tag;
            if (!e.r1 && cdb_valid && cdb_tag == e.q1) begin
               e.v1 = cdb_data;
               e.r1 = 1'b1;
            end
            if (!e.r3 && cdb_valid && cdb_tag == e.q3) begin
               e.v3 = cdb_data;
               e.r3 = 1'b1;
            end
            mq.push_back(e);
         end
      end
      @(posedge CLK);
      #1;
   endtask

   // Return all control inputs to idle (su_ready is left as set).
   task automatic idle_inputs();
      RST         = 1'b0;
      flush       = 1'b0;
      issue_valid = 1'b0;
      cdb_valid   = 1'b0;
   endtask

   // Present a store on the issue port.
   task automatic set_issue(input logic [31:0] v1, input logic [TAG_W-1:0] q1, input logic r1,
                            input logic [31:0] imm, input logic [31:0] v3,
                            input logic [TAG_W-1:0] q3, input logic r3,
                            input logic [2:0] mt, input logic [TAG_W-1:0] tag);
      issue_valid    = 1'b1;
      issue_v1       = v1;
      issue_q1       = q1;
      issue_v1_valid = r1;
      issue_imm      = imm;
      issue_v3       = v3;
      issue_q3       = q3;
      issue_v3_valid = r3;
      issue_mem_type = mt;
      issue_tag      = tag;
   endtask

   task automatic test_reset();
      idle_inputs();
      su_ready = 1'b0;
      RST = 1'b1;
      tick();
      RST = 1'b0;
      checks++;
      if (su_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_su_valid: got %b expected 0", su_valid);
      end
      checks++;
      if (issue_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_issue_ready: got %b expected 1", issue_ready);
      end
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL reset_count: got %0d expected 0", count);
      end
   endtask

   task automatic test_basic_issue();
      su_ready = 1'b1;
      set_issue(32'h1000, 4'd0, 1'b1, 32'd8, 32'hDEADBEEF, 4'd0, 1'b1, 3'b010, 4'd2);
      tick();
      idle_inputs();
      checks++;
      if (su_valid !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_su_valid: got %b expected 1", su_valid);
      end
      checks++;
      if (su_v1 !== 32'h1000 || su_v2 !== 32'd8 || su_v3 !== 32'hDEADBEEF) begin
         errors++;
         $display("[TB] FAIL basic_data: got %h/%h/%h expected 00001000/00000008/deadbeef",
                  su_v1, su_v2, su_v3);
      end
      checks++;
      if (su_mem_type !== 3'b010 || su_tag !== 4'd2) begin
         errors++;
         $display("[TB] FAIL basic_type_tag: got %b/%0d expected 010/2", su_mem_type, su_tag);
      end
      checks++;
      if ({su_v1_valid, su_v2_valid, su_v3_valid} !== 3'b111) begin
         errors++;
         $display("[TB] FAIL basic_op_valids: got %b expected 111",
                  {su_v1_valid, su_v2_valid, su_v3_valid});
      end
      checks++;
      if (count !== 3'd1) begin
         errors++;
         $display("[TB] FAIL basic_count_one: got %0d expected 1", count);
      end
      tick();
      checks++;
      if (count !== 3'd0 || su_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_popped: got count=%0d su_valid=%b expected 0/0", count, su_valid);
      end
   endtask

   task automatic test_cdb_capture();
      su_ready = 1'b1;
      set_issue(32'h0, 4'd5, 1'b0, 32'd4, 32'h11, 4'd0, 1'b1, 3'b000, 4'd1);
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (su_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL capture_wait_%0d: got su_valid=%b expected 0", i, su_valid);
         end
         if (i < 2) tick();
      end
      cdb_valid = 1'b1;
      cdb_tag   = 4'd5;
      cdb_data  = 32'h2000;
      tick();
      idle_inputs();
      checks++;
      if (su_valid !== 1'b1 || su_v1 !== 32'h2000) begin
         errors++;
         $display("[TB] FAIL capture_resolved: got su_valid=%b su_v1=%h expected 1/00002000",
                  su_valid, su_v1);
      end
      tick();
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL capture_drain: got count=%0d expected 0", count);
      end
   endtask

   task automatic test_issue_bypass();
      su_ready = 1'b1;
      set_issue(32'h40, 4'd0, 1'b1, 32'd0, 32'h0, 4'd7, 1'b0, 3'b001, 4'd3);
      cdb_valid = 1'b1;
      cdb_tag   = 4'd7;
      cdb_data  = 32'h55;
      tick();
      idle_inputs();
      checks++;
      if (su_valid !== 1'b1 || su_v3 !== 32'h55) begin
         errors++;
         $display("[TB] FAIL bypass: got su_valid=%b su_v3=%h expected 1/00000055", su_valid, su_v3);
      end
      tick();
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL bypass_drain: got count=%0d expected 0", count);
      end
   endtask

   task automatic test_full_and_wrap();
      logic [TAG_W-1:0] exp_tag;
      su_ready = 1'b0;
      for (int t = 0; t < 4; t++) begin
         set_issue(32'(t * 256), 4'd0, 1'b1, 32'(t), 32'(t), 4'd0, 1'b1, 3'(t), 4'(t));
         tick();
      end
      idle_inputs();
      checks++;
      if (issue_ready !== 1'b0 || count !== 3'd4) begin
         errors++;
         $display("[TB] FAIL full: got issue_ready=%b count=%0d expected 0/4", issue_ready, count);
      end
      set_issue(32'h9999, 4'd0, 1'b1, 32'd9, 32'd9, 4'd0, 1'b1, 3'b000, 4'd9);
      tick();
      idle_inputs();
      checks++;
      if (count !== 3'd4 || su_tag !== 4'd0) begin
         errors++;
         $display("[TB] FAIL full_ignore: got count=%0d su_tag=%0d expected 4/0", count, su_tag);
      end
      su_ready = 1'b1;
      tick();
      checks++;
      if (count !== 3'd3 || su_tag !== 4'd1) begin
         errors++;
         $display("[TB] FAIL pop_one: got count=%0d su_tag=%0d expected 3/1", count, su_tag);
      end
      for (int t = 4; t < 6; t++) begin
         set_issue(32'(t * 256), 4'd0, 1'b1, 32'(t), 32'(t), 4'd0, 1'b1, 3'(t), 4'(t));
         tick();
         checks++;
         if (count !== 3'd3 || su_tag !== 4'(t - 2)) begin
            errors++;
            $display("[TB] FAIL issue_pop_%0d: got count=%0d su_tag=%0d expected 3/%0d",
                     t, count, su_tag, t - 2);
         end
      end
      idle_inputs();
      for (int t = 3; t < 6; t++) begin
         exp_tag = 4'(t);
         checks++;
         if (su_valid !== 1'b1 || su_tag !== exp_tag || su_v1 !== 32'(t * 256)) begin
            errors++;
            $display("[TB] FAIL drain_order_%0d: got valid=%b tag=%0d v1=%h expected 1/%0d/%h",
                     t, su_valid, su_tag, su_v1, exp_tag, 32'(t * 256));
         end
         tick();
      end
      checks++;
      if (count !== 3'd0 || su_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL drain_empty: got count=%0d su_valid=%b expected 0/0", count, su_valid);
      end
   endtask

   task automatic test_in_order_dispatch();
      su_ready = 1'b1;
      set_issue(32'h0, 4'd3, 1'b0, 32'd12, 32'hAAAA, 4'd0, 1'b1, 3'b010, 4'd10);
      tick();
      set_issue(32'hB000, 4'd0, 1'b1, 32'd16, 32'hBBBB, 4'd0, 1'b1, 3'b010, 4'd11);
      tick();
      idle_inputs();
      checks++;
      if (su_valid !== 1'b0 || count !== 3'd2) begin
         errors++;
         $display("[TB] FAIL head_blocks: got su_valid=%b count=%0d expected 0/2", su_valid, count);
      end
      // A broadcast of the head's own tag must not resolve its base.
      cdb_valid = 1'b1;
      cdb_tag   = 4'd10;
      cdb_data  = 32'hFFFF;
      tick();
      idle_inputs();
      checks++;
      if (su_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL own_tag_ignored: got su_valid=%b expected 0", su_valid);
      end
      cdb_valid = 1'b1;
      cdb_tag   = 4'd3;
      cdb_data  = 32'h3000;
      tick();
      idle_inputs();
      checks++;
      if (su_valid !== 1'b1 || su_tag !== 4'd10 || su_v1 !== 32'h3000) begin
         errors++;
         $display("[TB] FAIL head_first: got valid=%b tag=%0d v1=%h expected 1/10/00003000",
                  su_valid, su_tag, su_v1);
      end
      tick();
      checks++;
      if (su_valid !== 1'b1 || su_tag !== 4'd11) begin
         errors++;
         $display("[TB] FAIL second_next: got valid=%b tag=%0d expected 1/11", su_valid, su_tag);
      end
      tick();
      checks++;
      if (count !== 3'd0) begin
         errors++;
         $display("[TB] FAIL order_drain: got count=%0d expected 0", count);
      end
   endtask

   task automatic test_flush(input bit use_rst);
      su_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         set_issue(32'(t), 4'd0, 1'b1, 32'd0, 32'd0, 4'd0, 1'b1, 3'b000, 4'(t));
         tick();
      end
      idle_inputs();
      checks++;
      if (count !== 3'd3) begin
         errors++;
         $display("[TB] FAIL flush_pre_%0d: got count=%0d expected 3", use_rst, count);
      end
      set_issue(32'h77, 4'd0, 1'b1, 32'd0, 32'd0, 4'd0, 1'b1, 3'b000, 4'd7);
      su_ready = 1'b1;
      if (use_rst) RST = 1'b1;
      else flush = 1'b1;
      tick();
      idle_inputs();
      checks++;
      if (count !== 3'd0 || su_valid !== 1'b0 || issue_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_post_%0d: got count=%0d su_valid=%b issue_ready=%b expected 0/0/1",
                  use_rst, count, su_valid, issue_ready);
      end
   endtask

   task automatic test_random();
      bit exp_valid;
      for (int cyc = 0; cyc < 600; cyc++) begin
         flush          = ($urandom_range(0, 99) < 3);
         issue_valid    = ($urandom_range(0, 99) < 60);
         issue_v1       = $urandom;
         issue_q1       = TAG_W'($urandom_range(0, 7));
         issue_v1_valid = ($urandom_range(0, 1) == 1);
         issue_imm      = $urandom;
         issue_v3       = $urandom;
         issue_q3       = TAG_W'($urandom_range(0, 7));
         issue_v3_valid = ($urandom_range(0, 1) == 1);
         issue_mem_type = 3'($urandom_range(0, 7));
         issue_tag      = TAG_W'($urandom_range(0, 15));
         cdb_valid      = ($urandom_range(0, 99) < 50);
         cdb_tag        = TAG_W'($urandom_range(0, 7));
         cdb_data       = $urandom;
         su_ready       = ($urandom_range(0, 99) < 60);
         tick();
         exp_valid = (mq.size() > 0) && mq[0].r1 && mq[0].r3;
         checks++;
         if (count !== CNT_W'(mq.size()) || issue_ready !== (mq.size() < DEPTH)) begin
            errors++;
            $display("[TB] FAIL rand_count_c%0d: got count=%0d ready=%b expected %0d/%b",
                     cyc, count, issue_ready, mq.size(), mq.size() < DEPTH);
         end
         checks++;
         if (su_valid !== exp_valid ||
             {su_v1_valid, su_v2_valid, su_v3_valid} !== {3{exp_valid}}) begin
            errors++;
            $display("[TB] FAIL rand_valid_c%0d: got %b (op %b%b%b) expected %b",
                     cyc, su_valid, su_v1_valid, su_v2_valid, su_v3_valid, exp_valid);
         end
         if (exp_valid) begin
            checks++;
            if (su_v1 !== mq[0].v1 || su_v2 !== mq[0].imm || su_v3 !== mq[0].v3 ||
                su_mem_type !== mq[0].mt || su_tag !== mq[0].tag) begin
               errors++;
               $display("[TB] FAIL rand_head_c%0d: got %h/%h/%h/%b/%0d expected %h/%h/%h/%b/%0d",
                        cyc, su_v1, su_v2, su_v3, su_mem_type, su_tag,
                        mq[0].v1, mq[0].imm, mq[0].v3, mq[0].mt, mq[0].tag);
            end
         end
      end
      idle_inputs();
   endtask

   // Scenario sequence.
   initial begin
      RST = 1'b1;
      flush = 1'b0;
      issue_valid = 1'b0;
      issue_v1 = '0;
      issue_q1 = '0;
      issue_v1_valid = 1'b0;
      issue_imm = '0;
      issue_v3 = '0;
      issue_q3 = '0;
      issue_v3_valid = 1'b0;
      issue_mem_type = '0;
      issue_tag = '0;
      cdb_valid = 1'b0;
      cdb_tag = '0;
      cdb_data = '0;
      su_ready = 1'b0;
      tick();
      tick();
      test_reset();
      test_basic_issue();
      test_cdb_capture();
      test_issue_bypass();
      test_full_and_wrap();
      test_in_order_dispatch();
      test_flush(1'b0);
      test_flush(1'b1);
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
